// File: rtl/regs_pkg.sv
// ============================================================================
// Module   : regs_pkg
// Brief    : Shared types and constants for the register file with flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regs_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Bit positions inside the status-flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_FLAG_W = 4;

endpackage

`default_nettype wire

// File: rtl/reg_clear_seq.sv
// ============================================================================
// Module   : reg_clear_seq
// Brief    : Sequenced-clear FSM; sweeps every address once, one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_clear_seq
    import regs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_we,
    output logic              o_clr_first
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = 1'b0;
        o_clr_we    = 1'b0;
        o_clr_first = 1'b0;
        o_clr_addr  = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                o_busy      = 1'b1;
                o_clr_we    = 1'b1;
                o_clr_first = (r_cnt == '0);
                w_cnt_nxt   = r_cnt + 1'b1;
                // Last address cleared this cycle: sweep complete
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_flags.sv
// ============================================================================
// Module   : reg_file_flags
// Brief    : 2R/1W register file with status flags and sequenced clear.
//            Define RF_BYPASS_EN to forward same-edge writes to the reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_flags
    import regs_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int FLAG_W   = DEF_FLAG_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_en,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] flags_out,
    input  logic              clr_req,
    output logic              busy
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic [FLAG_W-1:0] r_flags;
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_we;
    logic              w_clr_first;
    logic              w_wr_eff;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    reg_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .i_clr_req   (clr_req),
        .o_busy      (w_busy),
        .o_clr_addr  (w_clr_addr),
        .o_clr_we    (w_clr_we),
        .o_clr_first (w_clr_first)
    );

    // A clear request in IDLE wins over a write in the same cycle
    assign w_wr_eff = wr_en && !w_busy && !clr_req &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

`ifdef RF_BYPASS_EN
    assign w_byp_a = w_wr_eff && (wr_addr == rd_addr_a);
    assign w_byp_b = w_wr_eff && (wr_addr == rd_addr_b);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    always_comb begin
        w_rd_a = r_mem[rd_addr_a];
        w_rd_b = r_mem[rd_addr_b];
        if (w_byp_a) w_rd_a = wr_data;
        if (w_byp_b) w_rd_b = wr_data;
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) w_rd_a = '0;
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) w_rd_b = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_eff) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
        end else begin
            r_rd_a <= w_rd_a;
            r_rd_b <= w_rd_b;
            if (w_clr_first) begin
                r_flags <= '0;
            end else if (flags_en && !w_busy && !clr_req) begin
                r_flags <= flags_in;
            end
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign flags_out = r_flags;
    assign busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_flags.sv
// ============================================================================
// Module   : tb_reg_file_flags
// Brief    : Directed self-checking bench for reg_file_flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_flags;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        wr_en, flags_en, clr_req, busy;
    logic [3:0]  flags_in, flags_out;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    reg_file_flags #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .FLAG_W   (4),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flags_en  (flags_en),
        .flags_in  (flags_in),
        .flags_out (flags_out),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            step();
            check_eq({tag, "_a"}, rd_data_a, 32'h0);
            check_eq({tag, "_b"}, rd_data_b, 32'h0);
        end
    endtask

    task automatic fill_index();
        for (int i = 1; i < 32; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 32'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; flags_en = 1'b0; clr_req = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0; flags_in = '0;
        step(); step();
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_flags", 32'(flags_out), 32'h0);
        read_all_zero("rst_rd");

        // Basic write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        step();
        check_eq("r5_a", rd_data_a, 32'hDEADBEEF);
        check_eq("r5_b", rd_data_b, 32'hDEADBEEF);

        // Register 0 is hard-wired to zero
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step();
        wr_en = 1'b0; rd_addr_a = 5'd0;
        step();
        check_eq("r0_zero", rd_data_a, 32'h0);

        // Same-edge write and read of r7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr_a = 5'd7;
        step();
        wr_en = 1'b0;
`ifdef RF_BYPASS_EN
        check_eq("byp_r7", rd_data_a, 32'hA5A5A5A5);
`else
        check_eq("byp_r7", rd_data_a, 32'h0);
`endif
        step();
        check_eq("r7_next", rd_data_a, 32'hA5A5A5A5);

        // Flag load
        flags_en = 1'b1; flags_in = 4'b1010;
        step();
        flags_en = 1'b0;
        check_eq("flags_ld", 32'(flags_out), 32'hA);

        // Sequenced clear with a competing write and flag update
        fill_index();
        rd_addr_a = 5'd12; rd_addr_b = 5'd31;
        step();
        check_eq("fill_r12", rd_data_a, 32'd12);
        check_eq("fill_r31", rd_data_b, 32'd31);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF;
        flags_en = 1'b1; flags_in = 4'b0101;
        step();
        clr_req = 1'b0; flags_en = 1'b0;
        check_eq("clr_busy_on", 32'(busy), 32'h1);
        check_eq("clr_flag_drop", 32'(flags_out), 32'hA);
        busy_cnt = 1;
        rd_addr_a = 5'd3; wr_addr = 5'd9; wr_data = 32'h999;
        step();
        check_eq("clr_wr_drop", rd_data_a, 32'd3);
        while (busy && busy_cnt < 100) begin
            busy_cnt++;
            step();
        end
        wr_en = 1'b0;
        check_eq("clr_busy_len", 32'(busy_cnt), 32'd32);
        check_eq("clr_flags", 32'(flags_out), 32'h0);
        read_all_zero("clr_rd");

        // Reset in the middle of a clear sweep
        fill_index();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'h0);
        read_all_zero("abort_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
